// File: rtl/rem_pkg.sv
// Shared constants and helpers for the sign-magnitude remainder unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rem_pkg;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_MAG_W = DEF_WIDTH - 1;
    localparam int MAX_MAG_W = 64;

    // Callers zero-extend their magnitude, so one helper serves any WIDTH up to MAX_MAG_W+1.
    function automatic logic is_zero_mag(input logic [MAX_MAG_W-1:0] mag);
        return ~|mag;
    endfunction

endpackage

// File: rtl/rem_stage.sv
// One restoring-division row: shift in a dividend bit, trial-subtract, restore on borrow.
// Latency: combinational.
// Backpressure: none.
module rem_stage #(
    parameter int W = 2
) (
    input  logic [W-1:0] rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out
);

    logic [W:0]   shifted;
    logic [W+1:0] diff;
    logic         unused_hi;

    assign shifted = {rem_in, bit_in};
    assign diff    = {1'b0, shifted} - {2'b00, divisor};

    // rem_in < divisor, so the result is always below divisor and fits W bits.
    assign rem_out   = diff[W+1] ? shifted[W-1:0] : diff[W-1:0];
    assign unused_hi = diff[W];

endmodule

// File: rtl/rem.sv
// Sign-magnitude remainder: {num sign, |num| mod |den|}, flags zero divisor magnitude.
// Latency: 1 cycle (single output register), throughput 1 result per clk.
// Backpressure: none; inputs are sampled on every rising edge.
module rem
    import rem_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] numerator,
    input  logic [WIDTH-1:0] denominator,
    output logic [WIDTH-1:0] remainder,
    output logic             divbyzero
);

    localparam int MAG_W = WIDTH - 1;

    logic [MAG_W-1:0]           mag_n;
    logic [MAG_W-1:0]           mag_d;
    logic [MAG_W:0][MAG_W-1:0]  part;
    logic                       dz;
    logic [MAG_W-1:0]           rem_mag;
    logic                       unused_dsign;

    assign mag_n        = numerator[MAG_W-1:0];
    assign mag_d        = denominator[MAG_W-1:0];
    assign unused_dsign = denominator[WIDTH-1];
    assign part[0]      = '0;

    // Row g consumes dividend bits MSB first; quotient bits are never formed.
    for (genvar g = 0; g < MAG_W; g++) begin : g_row
        rem_stage #(
            .W (MAG_W)
        ) u_stage (
            .rem_in  (part[g]),
            .bit_in  (mag_n[MAG_W-1-g]),
            .divisor (mag_d),
            .rem_out (part[g+1])
        );
    end

    assign dz      = is_zero_mag(MAX_MAG_W'(mag_d));
    assign rem_mag = dz ? '0 : part[MAG_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remainder <= '0;
            divbyzero <= 1'b0;
        end else begin
            remainder <= {numerator[WIDTH-1], rem_mag};
            divbyzero <= dz;
        end
    end

endmodule

// File: tb/tb_rem.sv
// Scoreboard bench for rem: stimulus pushes expected results, a monitor pops and compares.
// Latency: checks one edge after each applied vector.
// Backpressure: n/a.
module tb_rem;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] numerator = '0;
    logic [2:0] denominator = '0;
    logic [2:0] remainder;
    logic       divbyzero;

    typedef struct {
        logic [2:0] rem;
        logic       dz;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rem dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .numerator   (numerator),
        .denominator (denominator),
        .remainder   (remainder),
        .divbyzero   (divbyzero)
    );

    task automatic check(input string name, input logic [2:0] r, input logic d,
                         input logic [2:0] er, input logic ed);
        checks++;
        if (r !== er || d !== ed) begin
            failures++;
            $display("FAIL %s: got remainder=%b divbyzero=%b, expected remainder=%b divbyzero=%b",
                     name, r, d, er, ed);
        end
    endtask

    // Reference: integer % on the 2-bit magnitudes, sign copied from numerator.
    function automatic logic [3:0] model(input logic [2:0] n, input logic [2:0] d);
        logic [1:0] mn;
        logic [1:0] md;
        mn = n[1:0];
        md = d[1:0];
        if (md == 2'd0) return {n[2], 2'b00, 1'b1};
        return {n[2], 2'(mn % md), 1'b0};
    endfunction

    task automatic apply(input logic [2:0] n, input logic [2:0] d,
                         input logic [2:0] er, input logic ed, input string name);
        @(negedge clk);
        numerator   = n;
        denominator = d;
        sb.push_back('{er, ed, name});
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, remainder, divbyzero, e.rem, e.dz);
        end
    end

    initial begin
        logic [3:0] m;

        #12;
        check("reset_init", remainder, divbyzero, 3'b000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        apply(3'b011, 3'b010, 3'b001, 1'b0, "011_mod_010");
        apply(3'b111, 3'b110, 3'b101, 1'b0, "111_mod_110");
        apply(3'b110, 3'b000, 3'b100, 1'b1, "div0_110_000");
        apply(3'b011, 3'b100, 3'b000, 1'b1, "div0_negzero_011_100");
        apply(3'b100, 3'b011, 3'b100, 1'b0, "zero_dividend_neg");
        apply(3'b010, 3'b011, 3'b010, 1'b0, "num_lt_den");

        // Async reset while outputs are non-zero, no clock edge in between.
        apply(3'b110, 3'b000, 3'b100, 1'b1, "pre_reset_div0");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        numerator   = 3'b011;
        denominator = 3'b010;
        #1;
        check("async_reset", remainder, divbyzero, 3'b000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", remainder, divbyzero, 3'b000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{3'b001, 1'b0, "post_reset_load"});

        for (int n = 0; n < 8; n++) begin
            for (int d = 0; d < 8; d++) begin
                m = model(3'(n), 3'(d));
                apply(3'(n), 3'(d), m[3:1], m[0], $sformatf("exh_%0d_%0d", n, d));
                repeat (9) @(posedge clk);
            end
        end

        apply(3'b001, 3'b011, 3'b001, 1'b0, "b2b_0");
        apply(3'b111, 3'b001, 3'b100, 1'b0, "b2b_1");
        apply(3'b011, 3'b011, 3'b000, 1'b0, "b2b_2");
        apply(3'b110, 3'b011, 3'b110, 1'b0, "b2b_3");
        apply(3'b101, 3'b010, 3'b101, 1'b0, "b2b_4");
        apply(3'b000, 3'b000, 3'b000, 1'b1, "b2b_5");
        apply(3'b111, 3'b010, 3'b101, 1'b0, "b2b_6");
        apply(3'b010, 3'b101, 3'b000, 1'b0, "b2b_7");

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
